serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial adder that feeds a single full-adder bit cell one operand bit per clock, LSB first. A carry flip-flop closes the loop between cycles. The full adder is instantiated as the combinational datapath, and this block supplies the sequencing around it: operand shift registers, the carry register, the bit counter, the control FSM and the result register. Its target use is a small-area alternative to a ripple-carry adder in lab designs.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on the rising edge.
- a  input  WIDTH  operand A; captured only when start is accepted.
- b  input  WIDTH  operand B; captured only when start is accepted.
- cin  input  1  carry-in; captured only when start is accepted.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out register.

Behaviour:
- Reset: single clock, reset asynchronous and active-low. While rst_n=0:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - shift registers, carry register and counter all cleared.
  - Reset asserted mid-operation aborts the addition immediately. No done pulse follows, and the partial result is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - If start=1 at an edge: load sh_a<=a, sh_b<=b, carry<=cin, cnt<=0, clear the shift-accumulator, go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - Each edge applies the full adder to sh_a[0], sh_b[0], carry.
  - Its sum bit shifts into the accumulator MSB (accumulator shifts right). The carry register takes the full-adder carry.
  - sh_a and sh_b shift right by one, filling with 0.
  - cnt increments.
  - On the edge where cnt==WIDTH-1: sum<=final accumulator value, cout<=full-adder carry, go to DONE.
  - ADD therefore occupies exactly WIDTH edges.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - If start=1 in DONE, it is accepted exactly as in IDLE (loads operands, goes to ADD), which allows back-to-back operations.
- Outputs:
  - busy=1 in ADD only.
  - done=1 in DONE only.
  - sum and cout change only on the completion edge and hold their value through IDLE and any following ADD until the next completion.
- Latency: start sampled at edge k → done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start in ADD is ignored; no queuing. Operand inputs a, b and cin are don't-care outside the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow wrap-around appears as cout=1 with sum holding the low WIDTH bits.

Test Plan (WIDTH=8):
- Basic add: a=0x5A, b=0x3C, cin=0, pulse start → busy high for 8 cycles, then done pulse for 1 cycle with sum=0x96, cout=0. Latency from the start edge to done is exactly 9 edges.
- Overflow: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start ignored while busy: start a=0x10, b=0x20; re-assert start with a=0xAA, b=0xAA at cycle 3 of ADD → single done with sum=0x30, cout=0. No second operation begins.
- Back-to-back: assert start during the DONE cycle with a=0x01, b=0x02 → first result delivered; second done arrives 9 edges later with sum=0x03. sum holds 0x30 until then.
- Reset mid-op: start a=0x7F, b=0x01, then drop rst_n asynchronously (between clock edges) at cycle 4 → busy, done, sum and cout go to 0 immediately. No done pulse after reset release; a subsequent start works normally.
- Random regression: 1000 random a, b, cin values against the reference a+b+cin model, with done asserted exactly once per accepted start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell stepped LSB first, with a carry
// flip-flop closing the loop between cycles.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_c,
    output logic co_c
);
    assign s_c  = a ^ b ^ ci;
    assign co_c = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned LAST = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sh_a, sh_b, acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               load_c, step_c, finish_c;
    logic               fa_s_c, fa_co_c;
    logic [WIDTH-1:0]   acc_nxt_c;

    serial_adder_fa u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .ci   (carry),
        .s_c  (fa_s_c),
        .co_c (fa_co_c)
    );

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 holds the LSB
    assign acc_nxt_c = {fa_s_c, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(LAST)) begin
                    finish_c  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Accepting here gives back-to-back operation
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry, counter and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load_c) begin
            sh_a  <= a;
            sh_b  <= b;
            acc   <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (step_c) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            acc   <= acc_nxt_c;
            carry <= fa_co_c;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == ADD);
            done <= (state_nxt == DONE);
            if (finish_c) begin
                sum  <= acc_nxt_c;
                cout <= fa_co_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected {cout,sum} queued at
// start, compared when done pulses.

module tb_serial_adder;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;

    int           vectors;
    int           miscompares;
    int           done_cnt;
    int           n_push;
    int           edges;
    logic [W:0]   sb[$];
    logic         prev_done;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result monitor: every done must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            chk("done_single_cycle", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                chk("result", 64'({cout, sum}), 64'(sb.pop_front()));
            end
        end
        prev_done = done;
    end

    // Called at a negedge; the start edge is the following posedge
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                            input bit push);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        cin   = tc;
        if (push) begin
            sb.push_back(({1'b0, ta} + {1'b0, tb_}) + (W+1)'(tc));
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Counts start-edge-relative edges until done; optionally checks sum holds
    task automatic wait_done(input int base, input bit hold_en, input logic [W-1:0] hold_val,
                             input bit chk_lat);
        int e;
        e = base;
        while (!done && e < 40) begin
            chk("busy_in_add", 64'(busy), 64'd1);
            if (hold_en) chk("sum_hold", 64'(sum), 64'(hold_val));
            @(negedge clk);
            e++;
        end
        if (!done) chk("timeout_done", 64'd0, 64'd1);
        else begin
            chk("busy_in_done", 64'(busy), 64'd0);
            if (chk_lat) chk("latency", 64'(e), 64'd9);
        end
        edges = e;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        n_push      = 0;
        prev_done   = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic add
        start_op(8'h5A, 8'h3C, 1'b0, 1'b1);
        wait_done(1, 1'b0, '0, 1'b1);
        chk("basic_sum", 64'(sum), 64'h96);
        @(negedge clk);
        chk("idle_after_done", 64'({busy, done}), 64'd0);

        // Overflow cases
        start_op(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done(1, 1'b0, '0, 1'b1);
        chk("ovf1", 64'({cout, sum}), 64'h100);
        @(negedge clk);
        start_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_done(1, 1'b0, '0, 1'b1);
        chk("ovf2", 64'({cout, sum}), 64'h1FF);
        @(negedge clk);

        // Start during ADD is ignored
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        start_op(8'hAA, 8'hAA, 1'b0, 1'b0);
        wait_done(4, 1'b0, '0, 1'b1);
        chk("ignore_sum", 64'({cout, sum}), 64'h030);

        // Back-to-back: start accepted in the DONE cycle
        start_op(8'h01, 8'h02, 1'b0, 1'b1);
        wait_done(1, 1'b1, 8'h30, 1'b1);
        chk("b2b_sum", 64'({cout, sum}), 64'h003);
        repeat (12) @(negedge clk);
        chk("no_second_op", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of an addition
        start_op(8'h7F, 8'h01, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_sum",  64'(sum),  64'd0);
        chk("arst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_idle", 64'({busy, done}), 64'd0);
        start_op(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_done(1, 1'b0, '0, 1'b1);
        chk("post_rst_sum", 64'({cout, sum}), 64'h080);
        @(negedge clk);

        // Random regression, alternating idle gaps and back-to-back starts
        for (int i = 0; i < 1000; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            wait_done(1, 1'b0, '0, 1'b1);
            if (i % 2 == 0) @(negedge clk);
        end
        repeat (15) @(negedge clk);

        chk("done_count", 64'(done_cnt), 64'(n_push));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
